lfsr_seq_gen: RTL and testbench

LFSR_SEQ_GEN -- requirements
Module: lfsr_seq_gen

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_next.sv | 26 ++
 rtl/lfsr_seq_gen.sv | 113 +++++++++++
 tb/tb_lfsr_seq_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared encodings and default constants for the LFSR sequence generator.
package lfsr_pkg;

  localparam int unsigned LFSR_FIB = 0;
  localparam int unsigned LFSR_GAL = 1;

  localparam int unsigned LFSR_DEF_WIDTH = 20;
  localparam logic [LFSR_DEF_WIDTH-1:0] LFSR_DEF_TAPS = 20'h08881;
  localparam logic [LFSR_DEF_WIDTH-1:0] LFSR_DEF_SEED = 20'h99999;

  // Which update the state register takes this cycle, in priority order.
  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_STEP    = 2'd1,
    UPD_RECOVER = 2'd2,
    UPD_LOAD    = 2'd3
  } lfsr_upd_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step LFSR successor, Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
  parameter int unsigned      MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt_c
);

  // Successor of cur; mode is fixed at elaboration.
  always_comb begin
    nxt_c = '0;
    if (MODE == LFSR_GAL) begin
      nxt_c[WIDTH-1] = cur[0];
      for (int i = 0; i < int'(WIDTH) - 1; i++) begin
        nxt_c[i] = cur[i+1] ^ (cur[0] & TAPS[i]);
      end
    end else begin
      nxt_c = {^(cur & TAPS), cur[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// LFSR sequence generator with load, lockup recovery, match trigger and step counter.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEF_SEED),
  parameter int unsigned      MODE  = LFSR_FIB,
  parameter int unsigned      CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             match_en,
  input  logic [WIDTH-1:0] match_val,
  input  logic             trig_clr,
  output logic [WIDTH-1:0] lfsr,
  output logic             match_hit,
  output logic             trig,
  output logic             wrap,
  output logic             lockup,
  output logic [CNT_W-1:0] steps
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             match_hit_q, match_hit_d;
  logic             trig_q, trig_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] nxt_c;
  lfsr_upd_e        upd_c;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_next (
    .cur   (lfsr_q),
    .nxt_c (nxt_c)
  );

  // Pick this cycle's update: load beats lockup recovery beats stepping.
  always_comb begin
    upd_c = UPD_HOLD;
    if (load) begin
      upd_c = UPD_LOAD;
    end else if (lfsr_q == '0) begin
      upd_c = UPD_RECOVER;
    end else if (en) begin
      upd_c = UPD_STEP;
    end
  end

  // Next-state values for every register.
  always_comb begin
    lfsr_d      = lfsr_q;
    steps_d     = steps_q;
    wrap_d      = 1'b0;
    lockup_d    = 1'b0;
    match_hit_d = match_en && (lfsr_q == match_val);
    // Clear dominates a simultaneous set from match_hit.
    trig_d      = trig_clr ? 1'b0 : (trig_q | match_hit_q);
    case (upd_c)
      UPD_LOAD: begin
        lfsr_d  = load_val;
        steps_d = '0;
      end
      UPD_RECOVER: begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end
      UPD_STEP: begin
        lfsr_d = nxt_c;
        if (steps_q != '1) begin
          steps_d = steps_q + CNT_W'(1);
        end
        wrap_d = (nxt_c == SEED);
      end
      UPD_HOLD: begin
      end
    endcase
  end

  // State registers; reset drops all pulses and returns to SEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q      <= SEED;
      steps_q     <= '0;
      match_hit_q <= 1'b0;
      trig_q      <= 1'b0;
      wrap_q      <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      steps_q     <= steps_d;
      match_hit_q <= match_hit_d;
      trig_q      <= trig_d;
      wrap_q      <= wrap_d;
      lockup_q    <= lockup_d;
    end
  end

  assign lfsr      = lfsr_q;
  assign steps     = steps_q;
  assign match_hit = match_hit_q;
  assign trig      = trig_q;
  assign wrap      = wrap_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Scoreboard bench: default Fibonacci, default Galois and a 4-bit Fibonacci instance.
module tb_lfsr_seq_gen;
  import lfsr_pkg::*;

  localparam logic [19:0] TB_TAPS = 20'h08881;
  localparam logic [19:0] TB_SEED = 20'h99999;

  typedef struct {
    logic [19:0] lfsr;
    logic [23:0] steps;
    logic        hit;
    logic        trig;
    logic        wrap;
    logic        lock;
  } st_t;

  logic        clk = 1'b0;
  logic        rst, en, load, match_en, trig_clr;
  logic [19:0] load_val, match_val;

  logic [19:0] lfsr1, lfsr3;
  logic [23:0] steps1, steps3;
  logic        hit1, trig1, wrap1, lock1;
  logic        hit3, trig3, wrap3, lock3;

  logic        en2, load2, match_en2, trig_clr2;
  logic [3:0]  load_val2, match_val2, lfsr2, steps2;
  logic        hit2, trig2, wrap2, lock2;

  int vectors;
  int miscompares;

  st_t m1, m3;
  st_t q1[$];
  st_t q3[$];

  always #5 clk = ~clk;

  lfsr_seq_gen u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .match_en(match_en), .match_val(match_val), .trig_clr(trig_clr),
    .lfsr(lfsr1), .match_hit(hit1), .trig(trig1), .wrap(wrap1),
    .lockup(lock1), .steps(steps1)
  );

  lfsr_seq_gen #(.MODE(LFSR_GAL)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .match_en(match_en), .match_val(match_val), .trig_clr(trig_clr),
    .lfsr(lfsr3), .match_hit(hit3), .trig(trig3), .wrap(wrap3),
    .lockup(lock3), .steps(steps3)
  );

  lfsr_seq_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(LFSR_FIB), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .en(en2), .load(load2), .load_val(load_val2),
    .match_en(match_en2), .match_val(match_val2), .trig_clr(trig_clr2),
    .lfsr(lfsr2), .match_hit(hit2), .trig(trig2), .wrap(wrap2),
    .lockup(lock2), .steps(steps2)
  );

  function automatic st_t rst_state();
    st_t s;
    s.lfsr = TB_SEED; s.steps = '0;
    s.hit = 1'b0; s.trig = 1'b0; s.wrap = 1'b0; s.lock = 1'b0;
    return s;
  endfunction

  // Reference behaviour of one clock edge.
  function automatic st_t model(st_t s, bit gal, logic ld, logic [19:0] lv,
                                logic e, logic me, logic [19:0] mv, logic tc);
    st_t n = s;
    logic fb;
    n.hit  = me && (s.lfsr == mv);
    n.trig = tc ? 1'b0 : (s.trig | s.hit);
    n.wrap = 1'b0;
    n.lock = 1'b0;
    if (ld) begin
      n.lfsr = lv; n.steps = '0;
    end else if (s.lfsr == 20'h0) begin
      n.lfsr = TB_SEED; n.lock = 1'b1;
    end else if (e) begin
      if (gal) begin
        n.lfsr = {s.lfsr[0], s.lfsr[19:1]} ^ (s.lfsr[0] ? (TB_TAPS & 20'h7FFFF) : 20'h0);
      end else begin
        fb = 1'b0;
        for (int i = 0; i < 20; i++) if (TB_TAPS[i]) fb = fb ^ s.lfsr[i];
        n.lfsr = {fb, s.lfsr[19:1]};
      end
      if (s.steps != 24'hFFFFFF) n.steps = s.steps + 24'd1;
      n.wrap = (n.lfsr == TB_SEED);
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    st_t e;
    e = q1.pop_front();
    cmp("fib_lfsr", 32'(lfsr1), 32'(e.lfsr));
    cmp("fib_steps", 32'(steps1), 32'(e.steps));
    cmp("fib_hit", 32'(hit1), 32'(e.hit));
    cmp("fib_trig", 32'(trig1), 32'(e.trig));
    cmp("fib_wrap", 32'(wrap1), 32'(e.wrap));
    cmp("fib_lockup", 32'(lock1), 32'(e.lock));
    e = q3.pop_front();
    cmp("gal_lfsr", 32'(lfsr3), 32'(e.lfsr));
    cmp("gal_steps", 32'(steps3), 32'(e.steps));
    cmp("gal_hit", 32'(hit3), 32'(e.hit));
    cmp("gal_trig", 32'(trig3), 32'(e.trig));
    cmp("gal_wrap", 32'(wrap3), 32'(e.wrap));
    cmp("gal_lockup", 32'(lock3), 32'(e.lock));
  endtask

  // Drive one cycle of stimulus, predict, then check after the edge.
  task automatic cycle(input logic ld, input logic [19:0] lv, input logic e,
                       input logic me, input logic [19:0] mv, input logic tc);
    @(negedge clk);
    load = ld; load_val = lv; en = e; match_en = me; match_val = mv; trig_clr = tc;
    m1 = model(m1, 1'b0, ld, lv, e, me, mv, tc);
    m3 = model(m3, 1'b1, ld, lv, e, me, mv, tc);
    q1.push_back(m1);
    q3.push_back(m3);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic check_reset_flags(input string tag);
    cmp({tag, "_lfsr"}, 32'(lfsr1), 32'(TB_SEED));
    cmp({tag, "_steps"}, 32'(steps1), 32'd0);
    cmp({tag, "_hit"}, 32'(hit1), 32'd0);
    cmp({tag, "_trig"}, 32'(trig1), 32'd0);
    cmp({tag, "_wrap"}, 32'(wrap1), 32'd0);
    cmp({tag, "_lockup"}, 32'(lock1), 32'd0);
    cmp({tag, "_gal_lfsr"}, 32'(lfsr3), 32'(TB_SEED));
  endtask

  initial begin
    logic [3:0] m2_lfsr;
    logic [3:0] m2_steps;
    logic       m2_wrap;
    int         wrap_cnt;

    vectors = 0; miscompares = 0;
    rst = 1'b0; en = 1'b0; load = 1'b0; match_en = 1'b0; trig_clr = 1'b0;
    load_val = '0; match_val = '0;
    en2 = 1'b0; load2 = 1'b0; match_en2 = 1'b0; trig_clr2 = 1'b0;
    load_val2 = '0; match_val2 = '0;

    #12;
    check_reset_flags("reset");
    cmp("small_reset_lfsr", 32'(lfsr2), 32'h1);
    cmp("small_reset_steps", 32'(steps2), 32'h0);
    m1 = rst_state(); m3 = rst_state();
    @(negedge clk);
    rst = 1'b1;

    // Two steps from reset while armed for 0xA6666.
    cycle(1'b0, 20'h0, 1'b1, 1'b1, 20'hA6666, 1'b0);
    cmp("seq_step1", 32'(lfsr1), 32'h4CCCC);
    cmp("seq_steps1", 32'(steps1), 32'd1);
    cycle(1'b0, 20'h0, 1'b1, 1'b1, 20'hA6666, 1'b0);
    cmp("seq_step2", 32'(lfsr1), 32'hA6666);
    cmp("seq_steps2", 32'(steps1), 32'd2);
    cmp("hit_not_early", 32'(hit1), 32'd0);
    cycle(1'b0, 20'h0, 1'b0, 1'b1, 20'hA6666, 1'b0);
    cmp("hit_pulse", 32'(hit1), 32'd1);
    cmp("hold_lfsr", 32'(lfsr1), 32'hA6666);
    cycle(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cmp("hit_single", 32'(hit1), 32'd0);
    cmp("trig_set", 32'(trig1), 32'd1);
    cycle(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cycle(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cmp("trig_sticky", 32'(trig1), 32'd1);
    // Clear arriving together with a fresh match_hit.
    cycle(1'b0, 20'h0, 1'b0, 1'b1, 20'hA6666, 1'b0);
    cycle(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b1);
    cmp("trig_clr_wins", 32'(trig1), 32'd0);
    cycle(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cmp("trig_stays_clr", 32'(trig1), 32'd0);

    // Load beats en.
    cycle(1'b1, 20'h12345, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("load_lfsr", 32'(lfsr1), 32'h12345);
    cmp("load_steps", 32'(steps1), 32'd0);

    // Random mix of stepping and matching.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 20'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? m1.lfsr : 20'h0, 1'($urandom_range(0, 7) == 0));
    end

    // Predecessor of SEED steps onto SEED; loading SEED does not wrap.
    cycle(1'b1, 20'h33333, 1'b0, 1'b0, 20'h0, 1'b0);
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("wrap_lfsr", 32'(lfsr1), 32'(TB_SEED));
    cmp("wrap_pulse", 32'(wrap1), 32'd1);
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("wrap_single", 32'(wrap1), 32'd0);
    cycle(1'b1, TB_SEED, 1'b0, 1'b0, 20'h0, 1'b0);
    cmp("wrap_not_on_load", 32'(wrap1), 32'd0);

    // Zero load then recovery with en ignored.
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cycle(1'b1, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0);
    cmp("zero_loaded", 32'(lfsr1), 32'h0);
    cmp("zero_no_lock", 32'(lock1), 32'd0);
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("recover_lfsr", 32'(lfsr1), 32'(TB_SEED));
    cmp("recover_lock", 32'(lock1), 32'd1);
    cmp("recover_steps", 32'(steps1), 32'd0);
    cmp("recover_no_wrap", 32'(wrap1), 32'd0);
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("lock_single", 32'(lock1), 32'd0);
    cmp("after_recover_steps", 32'(steps1), 32'd1);

    // Async reset while match_hit and trig are both high.
    cycle(1'b1, 20'hA6666, 1'b0, 1'b0, 20'h0, 1'b0);
    cycle(1'b0, 20'h0, 1'b0, 1'b1, 20'hA6666, 1'b0);
    cycle(1'b0, 20'h0, 1'b0, 1'b1, 20'hA6666, 1'b0);
    cmp("pre_rst_hit", 32'(hit1), 32'd1);
    cmp("pre_rst_trig", 32'(trig1), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_flags("async_rst");
    m1 = rst_state(); m3 = rst_state();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 20'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    cmp("post_rst_step", 32'(lfsr1), 32'h4CCCC);
    cmp("post_rst_hit", 32'(hit1), 32'd0);

    // Small instance: saturating counter and period-15 wrap.
    en = 1'b0; match_en = 1'b0;
    m2_lfsr = 4'h1; m2_steps = 4'h0; wrap_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      en2 = 1'b1;
      m2_lfsr  = {m2_lfsr[0] ^ m2_lfsr[1], m2_lfsr[3:1]};
      m2_steps = (m2_steps == 4'hF) ? 4'hF : m2_steps + 4'h1;
      m2_wrap  = (m2_lfsr == 4'h1);
      @(posedge clk);
      #1;
      cmp("small_lfsr", 32'(lfsr2), 32'(m2_lfsr));
      cmp("small_steps", 32'(steps2), 32'(m2_steps));
      cmp("small_wrap", 32'(wrap2), 32'(m2_wrap));
      if (wrap2) wrap_cnt++;
    end
    en2 = 1'b0;
    cmp("small_sat", 32'(steps2), 32'd15);
    cmp("small_wrap_count", 32'(wrap_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
